// File: rtl/bip_dmem_arbiter.sv
// bip_dmem_arbiter: shares the BIP data memory between the core (absolute priority) and a debug requester.
module bip_dmem_arbiter #(
  parameter int ADDRESS_BITS = 11,
  parameter int DATA_BITS    = 16,
  parameter int WAIT_BITS    = 8,
  parameter int MAX_WAIT     = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_halt,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [ADDRESS_BITS-1:0] cpu_address,
  input  logic [DATA_BITS-1:0]    cpu_wdata,
  output logic [DATA_BITS-1:0]    cpu_rdata,
  input  logic                    dbg_req,
  input  logic                    dbg_we,
  input  logic [ADDRESS_BITS-1:0] dbg_address,
  input  logic [DATA_BITS-1:0]    dbg_wdata,
  output logic                    dbg_busy,
  output logic                    dbg_ack,
  output logic [DATA_BITS-1:0]    dbg_rdata,
  output logic [WAIT_BITS-1:0]    dbg_wait,
  output logic                    dbg_starve,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_BITS-1:0]    mem_wdata,
  input  logic [DATA_BITS-1:0]    mem_rdata
);
  typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;
  state_t                  state_q, state_d;
  logic                    lwe_q, lwe_d, ack_q, ack_d, starve_q, starve_d, last_rd_q, last_rd_d;
  logic [ADDRESS_BITS-1:0] laddr_q, laddr_d;
  logic [DATA_BITS-1:0]    lwdata_q, lwdata_d, hold_q, hold_d, rdata_q, rdata_d;
  logic [WAIT_BITS-1:0]    wait_q, wait_d, wait_inc;
  logic                    grant;
  assign grant       = (state_q == PEND) & (~(cpu_read | cpu_write) | cpu_halt);
  assign mem_read    = grant ? ~lwe_q : cpu_read;
  assign mem_write   = grant ? lwe_q : cpu_write;
  assign mem_address = grant ? laddr_q : cpu_address;
  assign mem_wdata   = grant ? lwdata_q : cpu_wdata;
  // After a debug read the memory port returns debug data, so the core sees its last value instead
  assign cpu_rdata   = last_rd_q ? hold_q : mem_rdata;
  assign dbg_busy    = state_q != IDLE;
  assign dbg_ack     = ack_q;
  assign dbg_rdata   = rdata_q;
  assign dbg_wait    = wait_q;
  assign dbg_starve  = starve_q;
  assign wait_inc    = &wait_q ? wait_q : wait_q + 1'b1;
  always_comb begin
    state_d   = state_q;
    lwe_d     = lwe_q;
    laddr_d   = laddr_q;
    lwdata_d  = lwdata_q;
    wait_d    = wait_q;
    starve_d  = starve_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    last_rd_d = grant & ~lwe_q;
    hold_d    = cpu_rdata;
    case (state_q)
      IDLE: if (dbg_req) begin
        lwe_d    = dbg_we;
        laddr_d  = dbg_address;
        lwdata_d = dbg_wdata;
        wait_d   = '0;
        state_d  = PEND;
      end
      PEND: if (grant) begin
        ack_d   = lwe_q;
        state_d = lwe_q ? IDLE : RESP;
      end else begin
        wait_d   = wait_inc;
        starve_d = starve_q | (wait_inc >= WAIT_BITS'(MAX_WAIT));
      end
      RESP: begin
        rdata_d = mem_rdata;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      lwe_q     <= 1'b0;
      laddr_q   <= '0;
      lwdata_q  <= '0;
      wait_q    <= '0;
      starve_q  <= 1'b0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      last_rd_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      lwe_q     <= lwe_d;
      laddr_q   <= laddr_d;
      lwdata_q  <= lwdata_d;
      wait_q    <= wait_d;
      starve_q  <= starve_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      last_rd_q <= last_rd_d;
      hold_q    <= hold_d;
    end
  end
endmodule
